game_tick_gen: RTL and testbench

//  Upstream timing/control stage for the flappy-bird game core.

---
 rtl/game_tick_gen.sv | 232 +++++++++++++++++++++++
 tb/tb_game_tick_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_gen.sv
// game_tick_gen
//   Timing and control front end for the flappy-bird game core. Divides clk
//   down into the bird_clk and pipe_clock square waves. Runs the IDLE/PLAY/DEAD
//   game FSM. Ramps pipe speed with score and freezes the game on collision.
//
// Ports
//   clk           in   1  sole clock (CLOCK_50)
//   rst_n         in   1  asynchronous reset, active-low
//   press         in   1  player button, async; synchronised, rising edge used
//   collision     in   1  core collision flag, async; synchronised, level used
//   score_update  in   1  core score flag, async; synchronised, rising edge used
//   bird_clk      out  1  bird step clock, 50% duty, registered
//   pipe_clock    out  1  pipe shift clock, 50% duty, registered
//   bird_tick     out  1  one-cycle pulse on each bird_clk 0->1
//   pipe_tick     out  1  one-cycle pulse on each pipe_clock 0->1
//   game_state    out  2  00 IDLE, 01 PLAY, 10 DEAD
//   level         out  4  current speed level
//   game_rst      out  1  high while IDLE; holds the core in reset
//
// Configuration
//   GAME_SPEEDUP_EN  when defined, the score/level logic is built and the pipe
//                    half-period shrinks with level. When undefined, level is 0,
//                    the pipe half-period is fixed at PIPE_DIV_INIT and
//                    score_update is not used.
module game_tick_gen #(
  parameter int CNT_W           = 26,
  parameter int BIRD_DIV        = 6_250_000,
  parameter int PIPE_DIV_INIT   = 12_500_000,
  parameter int PIPE_DIV_MIN    = 3_125_000,
  parameter int PIPE_DIV_STEP   = 625_000,
  parameter int SCORE_PER_LEVEL = 5,
  parameter int DEAD_HOLD       = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       press,
  input  logic       collision,
  input  logic       score_update,
  output logic       bird_clk,
  output logic       pipe_clock,
  output logic       bird_tick,
  output logic       pipe_tick,
  output logic [1:0] game_state,
  output logic [3:0] level,
  output logic       game_rst
);

  localparam int HOLD_W = (DEAD_HOLD > 1) ? $clog2(DEAD_HOLD) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DEAD = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  // Two-flop synchronisers; press also gets an edge register.
  logic press_s1_q, press_s2_q, press_prev_q;
  logic coll_s1_q, coll_s2_q;
  logic press_rise;

  logic [CNT_W-1:0] bird_cnt_q, bird_cnt_d;
  logic [CNT_W-1:0] pipe_cnt_q, pipe_cnt_d;
  logic [CNT_W-1:0] pipe_div_q, pipe_div_d;
  logic [CNT_W-1:0] pipe_div_next;
  logic             bird_clk_q, bird_clk_d, bird_tick_q, bird_tick_d;
  logic             pipe_clk_q, pipe_clk_d, pipe_tick_q, pipe_tick_d;
  logic             bird_wrap, pipe_wrap, run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_s1_q   <= 1'b0;
      press_s2_q   <= 1'b0;
      press_prev_q <= 1'b0;
      coll_s1_q    <= 1'b0;
      coll_s2_q    <= 1'b0;
    end else begin
      press_s1_q   <= press;
      press_s2_q   <= press_s1_q;
      press_prev_q <= press_s2_q;
      coll_s1_q    <= collision;
      coll_s2_q    <= coll_s1_q;
    end
  end

  assign press_rise = press_s2_q & ~press_prev_q;

  // FSM: the hold counter defaults to 0, so it is already clear on DEAD entry.
  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    case (state_q)
      ST_IDLE: if (press_rise) state_d = ST_PLAY;
      ST_PLAY: if (coll_s2_q)  state_d = ST_DEAD;
      ST_DEAD: begin
        if (hold_q == HOLD_W'(DEAD_HOLD - 1)) state_d = ST_IDLE;
        else                                  hold_d  = hold_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

`ifdef GAME_SPEEDUP_EN
  localparam int SC_W = (SCORE_PER_LEVEL > 1) ? $clog2(SCORE_PER_LEVEL) : 1;

  logic            score_s1_q, score_s2_q, score_prev_q;
  logic            score_rise;
  logic [SC_W-1:0] score_cnt_q, score_cnt_d;
  logic [3:0]      level_q, level_d;

  // Pipe half-period for a level, clamped at PIPE_DIV_MIN. The arithmetic is
  // widened so a large level*step cannot wrap below the clamp.
  function automatic logic [CNT_W-1:0] pipe_div_for(input logic [3:0] lvl);
    logic [CNT_W+4:0] red;
    red = (CNT_W+5)'(lvl) * (CNT_W+5)'(PIPE_DIV_STEP);
    if (red + (CNT_W+5)'(PIPE_DIV_MIN) >= (CNT_W+5)'(PIPE_DIV_INIT))
      return CNT_W'(PIPE_DIV_MIN);
    return CNT_W'((CNT_W+5)'(PIPE_DIV_INIT) - red);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_s1_q   <= 1'b0;
      score_s2_q   <= 1'b0;
      score_prev_q <= 1'b0;
      score_cnt_q  <= '0;
      level_q      <= '0;
    end else begin
      score_s1_q   <= score_update;
      score_s2_q   <= score_s1_q;
      score_prev_q <= score_s2_q;
      score_cnt_q  <= score_cnt_d;
      level_q      <= level_d;
    end
  end

  assign score_rise = score_s2_q & ~score_prev_q;

  // A score edge coinciding with collision is dropped. Level stops rising at
  // 15 or once the pipe half-period has reached its clamp.
  always_comb begin
    score_cnt_d = score_cnt_q;
    level_d     = level_q;
    if (state_q == ST_IDLE && state_d == ST_PLAY) begin
      score_cnt_d = '0;
      level_d     = '0;
    end else if (state_q == ST_PLAY && !coll_s2_q && score_rise) begin
      if (score_cnt_q == SC_W'(SCORE_PER_LEVEL - 1)) begin
        score_cnt_d = '0;
        if (level_q != 4'hF && pipe_div_for(level_q) > CNT_W'(PIPE_DIV_MIN))
          level_d = level_q + 4'd1;
      end else begin
        score_cnt_d = score_cnt_q + 1'b1;
      end
    end
  end

  assign level         = level_q;
  assign pipe_div_next = pipe_div_for(level_q);
`else
  logic score_unused;
  assign score_unused  = score_update;
  assign level         = 4'd0;
  assign pipe_div_next = CNT_W'(PIPE_DIV_INIT);
`endif

  // Dividers only advance while PLAY continues into the next cycle. Leaving
  // PLAY drops both clocks low on the same edge that the state changes.
  assign run       = (state_q == ST_PLAY) && (state_d == ST_PLAY);
  assign bird_wrap = (bird_cnt_q == CNT_W'(BIRD_DIV - 1));
  assign pipe_wrap = (pipe_cnt_q == pipe_div_q - 1'b1);

  always_comb begin
    bird_cnt_d  = '0;
    bird_clk_d  = 1'b0;
    bird_tick_d = 1'b0;
    pipe_cnt_d  = '0;
    pipe_clk_d  = 1'b0;
    pipe_tick_d = 1'b0;
    pipe_div_d  = CNT_W'(PIPE_DIV_INIT);
    if (run) begin
      bird_cnt_d  = bird_wrap ? '0 : bird_cnt_q + 1'b1;
      bird_clk_d  = bird_clk_q ^ bird_wrap;
      bird_tick_d = bird_wrap & ~bird_clk_q;
      pipe_cnt_d  = pipe_wrap ? '0 : pipe_cnt_q + 1'b1;
      pipe_clk_d  = pipe_clk_q ^ pipe_wrap;
      pipe_tick_d = pipe_wrap & ~pipe_clk_q;
      // The new half-period is taken only at a wrap, so a half never stretches.
      pipe_div_d  = pipe_wrap ? pipe_div_next : pipe_div_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bird_cnt_q  <= '0;
      bird_clk_q  <= 1'b0;
      bird_tick_q <= 1'b0;
      pipe_cnt_q  <= '0;
      pipe_clk_q  <= 1'b0;
      pipe_tick_q <= 1'b0;
      pipe_div_q  <= CNT_W'(PIPE_DIV_INIT);
    end else begin
      bird_cnt_q  <= bird_cnt_d;
      bird_clk_q  <= bird_clk_d;
      bird_tick_q <= bird_tick_d;
      pipe_cnt_q  <= pipe_cnt_d;
      pipe_clk_q  <= pipe_clk_d;
      pipe_tick_q <= pipe_tick_d;
      pipe_div_q  <= pipe_div_d;
    end
  end

  assign bird_clk   = bird_clk_q;
  assign bird_tick  = bird_tick_q;
  assign pipe_clock = pipe_clk_q;
  assign pipe_tick  = pipe_tick_q;
  assign game_state = state_q;
  assign game_rst   = (state_q == ST_IDLE);

endmodule

// File: tb/tb_game_tick_gen.sv
module tb_game_tick_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       press = 1'b0;
  logic       collision = 1'b0;
  logic       score_update = 1'b0;
  logic       bird_clk, pipe_clock, bird_tick, pipe_tick, game_rst;
  logic [1:0] game_state;
  logic [3:0] level;

  int total_cnt = 0;
  int pass_cnt  = 0;

`ifdef GAME_SPEEDUP_EN
  localparam int EXP_LVL1 = 1;
  localparam int EXP_PER1 = 12;
  localparam int EXP_LVL2 = 2;
  localparam int EXP_PER2 = 8;
`else
  localparam int EXP_LVL1 = 0;
  localparam int EXP_PER1 = 16;
  localparam int EXP_LVL2 = 0;
  localparam int EXP_PER2 = 16;
`endif

  game_tick_gen #(
    .CNT_W(26), .BIRD_DIV(4), .PIPE_DIV_INIT(8), .PIPE_DIV_MIN(4),
    .PIPE_DIV_STEP(2), .SCORE_PER_LEVEL(2), .DEAD_HOLD(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .press(press), .collision(collision),
    .score_update(score_update), .bird_clk(bird_clk), .pipe_clock(pipe_clock),
    .bird_tick(bird_tick), .pipe_tick(pipe_tick), .game_state(game_state),
    .level(level), .game_rst(game_rst)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Cycles until the next bird_tick / pipe_tick; -1 if none within 100 cycles.
  task automatic wait_bird(output int cyc);
    cyc = 0;
    do begin tick(1); cyc++; end while (bird_tick !== 1'b1 && cyc < 100);
    if (bird_tick !== 1'b1) cyc = -1;
  endtask

  task automatic wait_pipe(output int cyc);
    cyc = 0;
    do begin tick(1); cyc++; end while (pipe_tick !== 1'b1 && cyc < 100);
    if (pipe_tick !== 1'b1) cyc = -1;
  endtask

  task automatic score_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      score_update = 1'b1; tick(2);
      score_update = 1'b0; tick(2);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(3);
    total_cnt++;
    if ({game_state, bird_clk, pipe_clock, bird_tick, pipe_tick, level, game_rst} !== 11'b00_0000_0000_1)
      $display("FAIL reset_state: got st=%b bc=%b pc=%b bt=%b pt=%b lvl=%0d rst=%b, want 00 0 0 0 0 0 1",
               game_state, bird_clk, pipe_clock, bird_tick, pipe_tick, level, game_rst);
    else pass_cnt++;
    rst_n = 1'b1;
    tick(2);
    total_cnt++;
    if (game_state !== 2'b00 || game_rst !== 1'b1)
      $display("FAIL idle_after_reset: got st=%b rst=%b, want 00 1", game_state, game_rst);
    else pass_cnt++;
  endtask

  task automatic test_start;
    int cyc;
    press = 1'b1;
    tick(2);
    total_cnt++;
    if (game_state !== 2'b00)
      $display("FAIL start_latency_2: got st=%b, want 00", game_state);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (game_state !== 2'b01 || game_rst !== 1'b0)
      $display("FAIL start_play: got st=%b rst=%b, want 01 0", game_state, game_rst);
    else pass_cnt++;
    press = 1'b0;
    tick(3);
    total_cnt++;
    if (bird_clk !== 1'b0)
      $display("FAIL bird_before_rise: got %b, want 0", bird_clk);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (bird_clk !== 1'b1 || bird_tick !== 1'b1)
      $display("FAIL bird_first_rise: got clk=%b tick=%b, want 1 1", bird_clk, bird_tick);
    else pass_cnt++;
    wait_bird(cyc);
    total_cnt++;
    if (cyc !== 8) $display("FAIL bird_period: got %0d, want 8", cyc);
    else pass_cnt++;
    wait_pipe(cyc);
    wait_pipe(cyc);
    total_cnt++;
    if (cyc !== 16) $display("FAIL pipe_period0: got %0d, want 16", cyc);
    else pass_cnt++;
  endtask

  task automatic test_speedup;
    int cyc;
    score_pulses(2);
    total_cnt++;
    if (level !== 4'(EXP_LVL1)) $display("FAIL level1: got %0d, want %0d", level, EXP_LVL1);
    else pass_cnt++;
    wait_pipe(cyc);
    wait_pipe(cyc);
    wait_pipe(cyc);
    total_cnt++;
    if (cyc !== EXP_PER1) $display("FAIL pipe_period1: got %0d, want %0d", cyc, EXP_PER1);
    else pass_cnt++;
    score_pulses(8);
    total_cnt++;
    if (level !== 4'(EXP_LVL2)) $display("FAIL level_capped: got %0d, want %0d", level, EXP_LVL2);
    else pass_cnt++;
    wait_pipe(cyc);
    wait_pipe(cyc);
    wait_pipe(cyc);
    total_cnt++;
    if (cyc !== EXP_PER2) $display("FAIL pipe_period2: got %0d, want %0d", cyc, EXP_PER2);
    else pass_cnt++;
  endtask

  task automatic test_collision;
    collision = 1'b1;
    tick(2);
    total_cnt++;
    if (game_state !== 2'b01) $display("FAIL coll_latency_2: got st=%b, want 01", game_state);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (game_state !== 2'b10 || bird_clk !== 1'b0 || pipe_clock !== 1'b0 || level !== 4'(EXP_LVL2))
      $display("FAIL dead_entry: got st=%b bc=%b pc=%b lvl=%0d, want 10 0 0 %0d",
               game_state, bird_clk, pipe_clock, level, EXP_LVL2);
    else pass_cnt++;
    press = 1'b1;
    tick(2);
    press = 1'b0;
    tick(7);
    total_cnt++;
    if (game_state !== 2'b10 || bird_clk !== 1'b0 || pipe_clock !== 1'b0 || bird_tick !== 1'b0)
      $display("FAIL dead_hold: got st=%b bc=%b pc=%b bt=%b, want 10 0 0 0",
               game_state, bird_clk, pipe_clock, bird_tick);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (game_state !== 2'b00 || game_rst !== 1'b1 || level !== 4'(EXP_LVL2))
      $display("FAIL dead_to_idle: got st=%b rst=%b lvl=%0d, want 00 1 %0d",
               game_state, game_rst, level, EXP_LVL2);
    else pass_cnt++;
    tick(4);
    total_cnt++;
    if (game_state !== 2'b00) $display("FAIL press_in_dead_ignored: got st=%b, want 00", game_state);
    else pass_cnt++;
    collision = 1'b0;
    tick(3);
  endtask

  task automatic test_simultaneous;
    press = 1'b1;
    tick(3);
    press = 1'b0;
    total_cnt++;
    if (game_state !== 2'b01 || level !== 4'd0)
      $display("FAIL restart_clears_level: got st=%b lvl=%0d, want 01 0", game_state, level);
    else pass_cnt++;
    score_pulses(1);
    collision    = 1'b1;
    score_update = 1'b1;
    tick(3);
    total_cnt++;
    if (game_state !== 2'b10 || level !== 4'd0)
      $display("FAIL simultaneous: got st=%b lvl=%0d, want 10 0", game_state, level);
    else pass_cnt++;
    collision    = 1'b0;
    score_update = 1'b0;
    tick(12);
    total_cnt++;
    if (game_state !== 2'b00) $display("FAIL sim_back_idle: got st=%b, want 00", game_state);
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    int cyc;
    press = 1'b1;
    tick(3);
    press = 1'b0;
    wait_bird(cyc);
    total_cnt++;
    if (game_state !== 2'b01 || bird_clk !== 1'b1)
      $display("FAIL play_before_reset: got st=%b bc=%b, want 01 1", game_state, bird_clk);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (game_state !== 2'b00 || bird_clk !== 1'b0 || pipe_clock !== 1'b0 || game_rst !== 1'b1)
      $display("FAIL async_reset: got st=%b bc=%b pc=%b rst=%b, want 00 0 0 1",
               game_state, bird_clk, pipe_clock, game_rst);
    else pass_cnt++;
    tick(3);
    total_cnt++;
    if (game_state !== 2'b00 || bird_clk !== 1'b0 || level !== 4'd0)
      $display("FAIL reset_hold: got st=%b bc=%b lvl=%0d, want 00 0 0", game_state, bird_clk, level);
    else pass_cnt++;
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_start();
    test_speedup();
    test_collision();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
